// File: rtl/lsq_pkg.sv
// lsq_pkg: shared types, constants and CDB tag-match helper for the in-order LS queue
package lsq_pkg;
  localparam int LSQ_DATA_W = 32;
  localparam int LSQ_TAG_W = 4;
  localparam int LSQ_NAME_W = 5;
  localparam int LSQ_OP_W = 6;
  localparam int LSQ_NUM_CDB = 2;
  localparam int CDB_IDX_W = LSQ_NUM_CDB > 1 ? $clog2(LSQ_NUM_CDB) : 1;
  localparam logic [LSQ_TAG_W-1:0] TAG_FREE = '0;
  localparam logic [LSQ_OP_W-1:0] NOP = '0;
  typedef struct packed {
    logic valid;
    logic [LSQ_OP_W-1:0] op;
    logic [LSQ_DATA_W-1:0] src1_data;
    logic [LSQ_TAG_W-1:0] src1_tag;
    logic [LSQ_DATA_W-1:0] src2_data;
    logic [LSQ_TAG_W-1:0] src2_tag;
    logic [LSQ_DATA_W-1:0] imm;
    logic [LSQ_TAG_W-1:0] dst_tag;
    logic [LSQ_NAME_W-1:0] dst_name;
  } lsq_entry_t;
  typedef struct packed {
    logic hit;
    logic [CDB_IDX_W-1:0] idx;
  } cdb_hit_t;
  // Scanning downwards lets the lowest matching channel overwrite the others.
  function automatic cdb_hit_t cdb_match(input logic [LSQ_TAG_W-1:0] tag,
                                         input logic [LSQ_NUM_CDB-1:0] cdb_valid,
                                         input logic [LSQ_NUM_CDB*LSQ_TAG_W-1:0] cdb_tag);
    cdb_match = '0;
    for (int k = LSQ_NUM_CDB - 1; k >= 0; k--)
      if (tag != TAG_FREE && cdb_valid[k] && cdb_tag[k*LSQ_TAG_W +: LSQ_TAG_W] == tag) begin
        cdb_match.hit = 1'b1;
        cdb_match.idx = k[CDB_IDX_W-1:0];
      end
  endfunction
endpackage

// File: rtl/lsq_cdb_snoop.sv
// lsq_cdb_snoop: next tag/data of one operand after snooping all CDB channels
module lsq_cdb_snoop
  import lsq_pkg::*;
(
  input  logic [LSQ_TAG_W-1:0] tag,
  input  logic [LSQ_DATA_W-1:0] data,
  input  logic [LSQ_NUM_CDB-1:0] cdb_valid,
  input  logic [LSQ_NUM_CDB*LSQ_TAG_W-1:0] cdb_tag,
  input  logic [LSQ_NUM_CDB*LSQ_DATA_W-1:0] cdb_data,
  output logic [LSQ_TAG_W-1:0] tag_nx,
  output logic [LSQ_DATA_W-1:0] data_nx
);
  cdb_hit_t m;
  assign m = cdb_match(tag, cdb_valid, cdb_tag);
  assign tag_nx = m.hit ? TAG_FREE : tag;
  assign data_nx = m.hit ? cdb_data[m.idx*LSQ_DATA_W +: LSQ_DATA_W] : data;
endmodule

// File: rtl/ls_order_queue.sv
// ls_order_queue: circular age-ordered LS queue issuing from the head once operands resolve.
// LSQ_ALLOC_BYPASS_EN also resolves allocating operands against the same-cycle CDB.
module ls_order_queue
  import lsq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DATA_W = LSQ_DATA_W,
  parameter int TAG_W = LSQ_TAG_W,
  parameter int NAME_W = LSQ_NAME_W,
  parameter int OP_W = LSQ_OP_W,
  parameter int NUM_CDB = LSQ_NUM_CDB
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic alloc_valid,
  output logic alloc_ready,
  input  logic [OP_W-1:0] alloc_op,
  input  logic [DATA_W-1:0] alloc_src1_data,
  input  logic [DATA_W-1:0] alloc_src2_data,
  input  logic [TAG_W-1:0] alloc_src1_tag,
  input  logic [TAG_W-1:0] alloc_src2_tag,
  input  logic [DATA_W-1:0] alloc_imm,
  input  logic [TAG_W-1:0] alloc_dst_tag,
  input  logic [NAME_W-1:0] alloc_dst_name,
  input  logic [NUM_CDB-1:0] cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic issue_valid,
  input  logic issue_ready,
  output logic [OP_W-1:0] issue_op,
  output logic [DATA_W-1:0] issue_src1,
  output logic [DATA_W-1:0] issue_src2,
  output logic [DATA_W-1:0] issue_imm,
  output logic [TAG_W-1:0] issue_dst_tag,
  output logic [NAME_W-1:0] issue_dst_name,
  output logic [$clog2(DEPTH):0] free_count,
  output logic empty
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  logic [PW-1:0] head, tail;
  lsq_entry_t q [DEPTH];
  lsq_entry_t hd, hz, ne;
  logic [TAG_W-1:0] s1_tag [DEPTH], s2_tag [DEPTH];
  logic [DATA_W-1:0] s1_data [DEPTH], s2_data [DEPTH];
  logic [TAG_W-1:0] a1_tag, a2_tag;
  logic [DATA_W-1:0] a1_data, a2_data;
  logic full, push, pop;
  for (genvar i = 0; i < DEPTH; i++) begin : g_snp
    lsq_cdb_snoop u_s1 (.tag(q[i].src1_tag), .data(q[i].src1_data), .cdb_valid, .cdb_tag, .cdb_data,
                        .tag_nx(s1_tag[i]), .data_nx(s1_data[i]));
    lsq_cdb_snoop u_s2 (.tag(q[i].src2_tag), .data(q[i].src2_data), .cdb_valid, .cdb_tag, .cdb_data,
                        .tag_nx(s2_tag[i]), .data_nx(s2_data[i]));
  end
`ifdef LSQ_ALLOC_BYPASS_EN
  lsq_cdb_snoop u_a1 (.tag(alloc_src1_tag), .data(alloc_src1_data), .cdb_valid, .cdb_tag, .cdb_data,
                      .tag_nx(a1_tag), .data_nx(a1_data));
  lsq_cdb_snoop u_a2 (.tag(alloc_src2_tag), .data(alloc_src2_data), .cdb_valid, .cdb_tag, .cdb_data,
                      .tag_nx(a2_tag), .data_nx(a2_data));
`else
  assign a1_tag = alloc_src1_tag;
  assign a2_tag = alloc_src2_tag;
  assign a1_data = alloc_src1_data;
  assign a2_data = alloc_src2_data;
`endif
  assign ne = '{valid: 1'b1, op: alloc_op, src1_data: a1_data, src1_tag: a1_tag, src2_data: a2_data,
                src2_tag: a2_tag, imm: alloc_imm, dst_tag: alloc_dst_tag, dst_name: alloc_dst_name};
  assign full = head[AW-1:0] == tail[AW-1:0] && head[AW] != tail[AW];
  assign empty = head == tail;
  assign alloc_ready = !full;
  assign free_count = DEPTH_P - (tail - head);
  assign hd = q[head[AW-1:0]];
  assign hz = hd.valid ? hd : '0;
  assign issue_valid = hd.valid && hd.src1_tag == TAG_FREE && hd.src2_tag == TAG_FREE;
  assign issue_op = hz.op;
  assign issue_src1 = hz.src1_data;
  assign issue_src2 = hz.src2_data;
  assign issue_imm = hz.imm;
  assign issue_dst_tag = hz.dst_tag;
  assign issue_dst_name = hz.dst_name;
  assign push = alloc_valid && !full;
  assign pop = issue_valid && issue_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (q[i].valid) begin
          q[i].src1_tag <= s1_tag[i];
          q[i].src1_data <= s1_data[i];
          q[i].src2_tag <= s2_tag[i];
          q[i].src2_data <= s2_data[i];
        end
      if (pop) begin
        q[head[AW-1:0]].valid <= 1'b0;
        head <= head + 1'b1;
      end
      if (push) begin
        q[tail[AW-1:0]] <= ne;
        tail <= tail + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ls_order_queue.sv
// tb_ls_order_queue: directed plus random stimulus checked against a queue-based reference model
module tb_ls_order_queue;
  logic clk = 0, rst = 1, flush = 0, alloc_valid = 0, issue_ready = 0;
  logic alloc_ready, issue_valid, empty;
  logic [5:0] alloc_op = 0, issue_op;
  logic [31:0] alloc_src1_data = 0, alloc_src2_data = 0, alloc_imm = 0, issue_src1, issue_src2, issue_imm;
  logic [3:0] alloc_src1_tag = 0, alloc_src2_tag = 0, alloc_dst_tag = 0, issue_dst_tag, free_count;
  logic [4:0] alloc_dst_name = 0, issue_dst_name;
  logic [1:0] cdb_valid = 0;
  logic [7:0] cdb_tag = 0;
  logic [63:0] cdb_data = 0;
  int total = 0, bad = 0, nxt;
  typedef struct packed {
    logic [5:0] op;
    logic [31:0] d1;
    logic [3:0] t1;
    logic [31:0] d2;
    logic [3:0] t2;
    logic [31:0] imm;
    logic [3:0] dt;
    logic [4:0] dn;
  } m_t;
  m_t mq[$];
  ls_order_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_op(alloc_op), .alloc_src1_data(alloc_src1_data), .alloc_src2_data(alloc_src2_data),
    .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag), .alloc_imm(alloc_imm),
    .alloc_dst_tag(alloc_dst_tag), .alloc_dst_name(alloc_dst_name), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_imm(issue_imm),
    .issue_dst_tag(issue_dst_tag), .issue_dst_name(issue_dst_name), .free_count(free_count),
    .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic m_t snoop(input m_t e);
    for (int k = 0; k < 2; k++) begin
      if (cdb_valid[k] && e.t1 != 0 && cdb_tag[k*4 +: 4] == e.t1) begin
        e.d1 = cdb_data[k*32 +: 32];
        e.t1 = 0;
      end
      if (cdb_valid[k] && e.t2 != 0 && cdb_tag[k*4 +: 4] == e.t2) begin
        e.d2 = cdb_data[k*32 +: 32];
        e.t2 = 0;
      end
    end
    return e;
  endfunction
  task automatic model_edge();
    m_t e;
    bit pop, push;
    if (flush) begin
      mq.delete();
      return;
    end
    pop = mq.size() > 0 && mq[0].t1 == 0 && mq[0].t2 == 0 && issue_ready;
    push = alloc_valid && mq.size() < 8;
    for (int i = 0; i < mq.size(); i++) mq[i] = snoop(mq[i]);
    e = '{op: alloc_op, d1: alloc_src1_data, t1: alloc_src1_tag, d2: alloc_src2_data, t2: alloc_src2_tag,
          imm: alloc_imm, dt: alloc_dst_tag, dn: alloc_dst_name};
`ifdef LSQ_ALLOC_BYPASS_EN
    e = snoop(e);
`endif
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(e);
  endtask
  task automatic compare();
    m_t h = mq.size() > 0 ? mq[0] : '0;
    bit ev = mq.size() > 0 && h.t1 == 0 && h.t2 == 0;
    check("issue_valid", issue_valid, ev);
    check("alloc_ready", alloc_ready, mq.size() < 8);
    check("empty", empty, mq.size() == 0);
    check("free_count", free_count, 8 - mq.size());
    check("issue_op", issue_op, h.op);
    check("issue_imm", issue_imm, h.imm);
    check("issue_dst_tag", issue_dst_tag, h.dt);
    check("issue_dst_name", issue_dst_name, h.dn);
    if (ev) begin
      check("issue_src1", issue_src1, h.d1);
      check("issue_src2", issue_src2, h.d2);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask
  task automatic idle();
    alloc_valid = 0;
    cdb_valid = 0;
    issue_ready = 0;
    flush = 0;
  endtask
  task automatic put(input logic [5:0] op, input logic [3:0] t1, input logic [3:0] t2, input logic [31:0] d1);
    alloc_valid = 1;
    alloc_op = op;
    alloc_src1_tag = t1;
    alloc_src2_tag = t2;
    alloc_src1_data = d1;
    alloc_src2_data = ~d1;
    alloc_imm = {26'h0, op};
    alloc_dst_tag = op[3:0];
    alloc_dst_name = op[4:0];
  endtask
  task automatic clear_q();
    idle();
    flush = 1;
    cycle();
    flush = 0;
  endtask
  task automatic rnd();
    if ($urandom_range(0, 3) != 0)
      put(6'($urandom_range(1, 63)), $urandom_range(0, 1) != 0 ? 4'd0 : 4'($urandom_range(1, 7)),
          $urandom_range(0, 2) != 0 ? 4'd0 : 4'($urandom_range(1, 7)), $urandom);
    else alloc_valid = 0;
    cdb_valid = 2'($urandom_range(0, 3));
    cdb_tag = {4'($urandom_range(1, 7)), 4'($urandom_range(1, 7))};
    cdb_data = {$urandom, $urandom};
    issue_ready = $urandom_range(0, 3) != 0;
    flush = $urandom_range(0, 79) == 0;
  endtask
  initial begin
    #2;
    check("rst_issue_valid", issue_valid, 0);
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_free_count", free_count, 8);
    check("rst_issue_op", issue_op, 0);
    #10 rst = 0;
    cycle();
    put(1, 3, 0, 32'h1111);
    cycle();
    put(2, 0, 0, 32'h2222);
    issue_ready = 1;
    cycle();
    check("blocked_valid", issue_valid, 0);
    alloc_valid = 0;
    cdb_valid = 2'b01;
    cdb_tag = 8'h03;
    cdb_data = {32'h0, 32'hDEADBEEF};
    cycle();
    check("a_issue_op", issue_op, 1);
    check("a_issue_src1", issue_src1, 32'hDEADBEEF);
    cdb_valid = 0;
    cycle();
    check("b_issue_op", issue_op, 2);
    cycle();
    check("drained", empty, 1);
    idle();
    for (int i = 1; i <= 8; i++) begin
      put(6'(i), 0, 0, 32'(i));
      cycle();
    end
    alloc_valid = 0;
    check("full_ready", alloc_ready, 0);
    check("full_free", free_count, 0);
    nxt = 1;
    issue_ready = 1;
    for (int c = 0; c < 16; c++) begin
      if (issue_valid) begin
        check("order", issue_op, nxt);
        nxt++;
      end
      if (c == 0) put(63, 0, 0, 0);
      else if (c <= 3) put(6'(8 + c), 0, 0, 32'(c));
      else alloc_valid = 0;
      cycle();
      if (c == 0) check("full_refuse", free_count, 1);
    end
    check("order_end", nxt, 12);
    idle();
    for (int i = 0; i < 4; i++) begin
      put(6'(20 + i), 0, 0, 0);
      cycle();
    end
    put(30, 0, 0, 0);
    issue_ready = 1;
    cycle();
    check("alloc_pop_free", free_count, 4);
    clear_q();
    put(40, 5, 6, 0);
    cycle();
    alloc_valid = 0;
    cdb_valid = 2'b11;
    cdb_tag = {4'd5, 4'd6};
    cdb_data = {32'hBBBB0005, 32'hAAAA0006};
    cycle();
    check("dual_valid", issue_valid, 1);
    check("dual_src1", issue_src1, 32'hBBBB0005);
    check("dual_src2", issue_src2, 32'hAAAA0006);
    idle();
    for (int i = 0; i < 5; i++) begin
      put(6'(50 + i), 0, 0, 0);
      cycle();
    end
    put(60, 0, 0, 0);
    flush = 1;
    cycle();
    flush = 0;
    alloc_valid = 0;
    check("flush_empty", empty, 1);
    check("flush_free", free_count, 8);
    check("flush_valid", issue_valid, 0);
    cycle();
    check("flush_alloc_lost", empty, 1);
`ifdef LSQ_ALLOC_BYPASS_EN
    put(7, 4, 0, 0);
    cdb_valid = 2'b01;
    cdb_tag = 8'h04;
    cdb_data = {32'h0, 32'h1234};
    cycle();
    check("bypass_valid", issue_valid, 1);
    check("bypass_src1", issue_src1, 32'h1234);
    clear_q();
`endif
    for (int i = 0; i < 1500; i++) begin
      rnd();
      cycle();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      put(6'(10 + i), 0, 0, 0);
      cycle();
    end
    alloc_valid = 0;
    issue_ready = 1;
    cycle();
    #3 rst = 1;
    #1;
    check("arst_issue_valid", issue_valid, 0);
    check("arst_alloc_ready", alloc_ready, 1);
    check("arst_empty", empty, 1);
    check("arst_free_count", free_count, 8);
    check("arst_issue_op", issue_op, 0);
    mq.delete();
    idle();
    @(negedge clk);
    rst = 0;
    cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
